// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port owner encoding,
// default word-index width and the request payload layout.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 10;

  typedef enum logic {
    DMEM_PORT_CORE = 1'b0,
    DMEM_PORT_AUX  = 1'b1
  } dmem_port_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Winner select: core has fixed priority unless aux has starved for
// STARVE_MAX consecutive cycles.
module dmem_arb_prio #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       core_req,
  input  logic       aux_req,
  input  logic [3:0] starve_cnt,
  output logic       core_win,
  output logic       aux_win
);

  always_comb begin
    aux_win  = aux_req & (~core_req | (starve_cnt == 4'(STARVE_MAX)));
    core_win = core_req & ~aux_win;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory (core + aux).
// Optional DMEM_ARB_ERR_EN: reject misaligned/out-of-range addresses with err.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DMEM_ADDR_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  output logic              core_err,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [31:0]       aux_addr,
  input  logic [31:0]       aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [31:0]       aux_rdata,
  output logic              aux_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_ReadEnable,
  output logic              mem_WriteEnable,
  input  logic [31:0]       mem_data
);

  logic [3:0]        starve_cnt;
  logic              rd_pend;
  dmem_port_e        rd_owner;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       core_rdata_q;
  logic [31:0]       aux_rdata_q;

  logic      core_win;
  logic      aux_win;
  logic      gnt_raw;
  logic      rd_raw;
  logic      wr_raw;
  logic      core_bad;
  logic      aux_bad;
  logic      win_bad;
  dmem_req_t win;
  logic      unused_addr_bits;

  dmem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .core_req   (core_req),
    .aux_req    (aux_req),
    .starve_cnt (starve_cnt),
    .core_win   (core_win),
    .aux_win    (aux_win)
  );

`ifdef DMEM_ARB_ERR_EN
  assign core_bad = (core_addr[1:0] != 2'b00) | (core_addr[31:ADDR_W+2] != '0);
  assign aux_bad  = (aux_addr[1:0] != 2'b00) | (aux_addr[31:ADDR_W+2] != '0);
`else
  assign core_bad = 1'b0;
  assign aux_bad  = 1'b0;
`endif

  always_comb begin
    win     = aux_win ? '{we: aux_we, addr: aux_addr, wdata: aux_wdata}
                      : '{we: core_we, addr: core_addr, wdata: core_wdata};
    win_bad = aux_win ? aux_bad : core_bad;
    gnt_raw = core_win | aux_win;
    rd_raw  = gnt_raw & ~win_bad & ~win.we;
    wr_raw  = gnt_raw & ~win_bad & win.we;
  end

  assign unused_addr_bits = ^{win.addr[31:ADDR_W+2], win.addr[1:0]};

  // Grant-side outputs are forced low while reset is asserted.
  assign core_gnt        = core_win & reset;
  assign aux_gnt         = aux_win & reset;
  assign core_err        = core_win & core_bad & reset;
  assign aux_err         = aux_win & aux_bad & reset;
  assign mem_ReadEnable  = rd_raw & reset;
  assign mem_WriteEnable = wr_raw & reset;
  assign mem_address     = (gnt_raw & reset) ? win.addr[ADDR_W+1:2] : addr_q;
  assign mem_data_in     = (gnt_raw & reset) ? win.wdata : wdata_q;

  assign core_rvalid = rd_pend & (rd_owner == DMEM_PORT_CORE);
  assign aux_rvalid  = rd_pend & (rd_owner == DMEM_PORT_AUX);
  assign core_rdata  = core_rvalid ? mem_data : core_rdata_q;
  assign aux_rdata   = aux_rvalid ? mem_data : aux_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt   <= 4'd0;
      rd_pend      <= 1'b0;
      rd_owner     <= DMEM_PORT_CORE;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      core_rdata_q <= 32'd0;
      aux_rdata_q  <= 32'd0;
    end else begin
      if (!aux_req || aux_win) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != 4'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      if (gnt_raw) begin
        addr_q  <= win.addr[ADDR_W+1:2];
        wdata_q <= win.wdata;
      end
      rd_pend <= rd_raw;
      if (rd_raw) begin
        rd_owner <= aux_win ? DMEM_PORT_AUX : DMEM_PORT_CORE;
      end
      if (core_rvalid) core_rdata_q <= mem_data;
      if (aux_rvalid)  aux_rdata_q  <= mem_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle behavioural model plus
// directed scenarios with literal expectations.
module tb_dmem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, aux_req, aux_we;
  logic [31:0]   core_addr, core_wdata, aux_addr, aux_wdata;
  logic          core_gnt, core_rvalid, core_err, aux_gnt, aux_rvalid, aux_err;
  logic [31:0]   core_rdata, aux_rdata;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_in, mem_data;
  logic          mem_ReadEnable, mem_WriteEnable;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_err(core_err),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
    .aux_rdata(aux_rdata), .aux_err(aux_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_ReadEnable(mem_ReadEnable), .mem_WriteEnable(mem_WriteEnable),
    .mem_data(mem_data)
  );

  function automatic logic [31:0] init_val(input int idx);
    return (idx == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(idx));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous DataMemory: read data appears the cycle after the strobe.
  logic [31:0] ram [0:(1<<AW)-1];
  bit init_done;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_val(i);
      init_done <= 1'b1;
      mem_data  <= 32'd0;
    end else begin
      if (mem_WriteEnable) ram[mem_address] <= mem_data_in;
      if (mem_ReadEnable)  mem_data <= ram[mem_address];
    end
  end

  // Behavioural model, evaluated mid-cycle.
  logic [31:0] wr_map [int];
  int          aux_wait = 0;
  bit          pend_v = 0;
  bit          pend_aux = 0;
  logic [31:0] pend_data = 0;
  logic [31:0] exp_crd = 0, exp_ard = 0, exp_wd = 0;
  int          exp_idx = 0;

  always @(negedge clk) begin
    bit e_aux, e_core, e_g, w_we, w_bad;
    logic [31:0] w_addr, w_wd;
    int idx;
    if (!reset) begin
      chk("rst_core_gnt", core_gnt, 0);
      chk("rst_aux_gnt", aux_gnt, 0);
      chk("rst_strobes", {mem_ReadEnable, mem_WriteEnable}, 0);
      chk("rst_rvalid", {core_rvalid, aux_rvalid}, 0);
      chk("rst_rdata", core_rdata | aux_rdata, 0);
      chk("rst_mem_out", mem_data_in | 32'(mem_address), 0);
      chk("rst_err", {core_err, aux_err}, 0);
      aux_wait = 0; pend_v = 0; exp_crd = 0; exp_ard = 0; exp_wd = 0; exp_idx = 0;
    end else begin
      if (pend_v && !pend_aux) exp_crd = pend_data;
      if (pend_v && pend_aux)  exp_ard = pend_data;
      chk("core_rvalid", core_rvalid, pend_v && !pend_aux);
      chk("aux_rvalid", aux_rvalid, pend_v && pend_aux);
      chk("core_rdata", core_rdata, exp_crd);
      chk("aux_rdata", aux_rdata, exp_ard);
      e_aux  = aux_req && (!core_req || aux_wait >= SM);
      e_core = core_req && !e_aux;
      e_g    = e_aux || e_core;
      w_we   = e_aux ? aux_we : core_we;
      w_addr = e_aux ? aux_addr : core_addr;
      w_wd   = e_aux ? aux_wdata : core_wdata;
`ifdef DMEM_ARB_ERR_EN
      w_bad  = (w_addr % 4 != 0) || ((w_addr >> (AW + 2)) != 0);
`else
      w_bad  = 1'b0;
`endif
      idx = int'((w_addr >> 2) % (1 << AW));
      chk("core_gnt", core_gnt, e_core);
      chk("aux_gnt", aux_gnt, e_aux);
      chk("core_err", core_err, e_core && w_bad);
      chk("aux_err", aux_err, e_aux && w_bad);
      chk("mem_re", mem_ReadEnable, e_g && !w_bad && !w_we);
      chk("mem_we", mem_WriteEnable, e_g && !w_bad && w_we);
      if (e_g) begin exp_idx = idx; exp_wd = w_wd; end
      chk("mem_address", 32'(mem_address), exp_idx);
      chk("mem_data_in", mem_data_in, exp_wd);
      pend_v   = e_g && !w_bad && !w_we;
      pend_aux = e_aux;
      if (pend_v) pend_data = wr_map.exists(idx) ? wr_map[idx] : init_val(idx);
      if (e_g && !w_bad && w_we) wr_map[idx] = w_wd;
      aux_wait = (aux_req && !e_aux) ? ((aux_wait + 1 > SM) ? SM : aux_wait + 1) : 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout %0d of %0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [9:0] aux_pat, core_pat;
    reset = 1'b0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Core-only load of word 4
    core_addr = 32'h10; core_req = 1;
    @(negedge clk);
    chk("t1_gnt", core_gnt, 1);
    chk("t1_addr", 32'(mem_address), 4);
    step(); core_req = 0;
    @(negedge clk);
    chk("t1_rvalid", core_rvalid, 1);
    chk("t1_rdata", core_rdata, 32'hDEADBEEF);
    chk("t1_aux_rvalid", aux_rvalid, 0);

    // Aux store then load of 0x20
    step();
    aux_req = 1; aux_we = 1; aux_addr = 32'h20; aux_wdata = 32'h12345678;
    @(negedge clk);
    chk("t2_wr_gnt", aux_gnt, 1);
    chk("t2_we", mem_WriteEnable, 1);
    step(); aux_we = 0;
    @(negedge clk);
    chk("t2_rd_gnt", aux_gnt, 1);
    step(); aux_req = 0;
    @(negedge clk);
    chk("t2_rdata", aux_rdata, 32'h12345678);
    chk("t2_core_hold", core_rdata, 32'hDEADBEEF);

    // Contention: aux forced through every fifth cycle
    step();
    core_req = 1; core_addr = 32'h40; aux_req = 1; aux_addr = 32'h44;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      aux_pat[i] = aux_gnt; core_pat[i] = core_gnt;
      step();
    end
    core_req = 0; aux_req = 0;
    chk("t3_aux_pat", 32'(aux_pat), 32'h210);
    chk("t3_core_pat", 32'(core_pat), 32'h1EF);

    // Alternating core/aux reads on consecutive cycles
    step();
    for (int i = 0; i < 7; i++) begin
      core_req = (i < 6) && (i % 2 == 0); core_addr = 32'h10;
      aux_req  = (i < 6) && (i % 2 == 1); aux_addr  = 32'h20;
      @(negedge clk);
      if (i > 0) begin
        chk("t4_core_rv", core_rvalid, (i - 1) % 2 == 0);
        chk("t4_aux_rv", aux_rvalid, (i - 1) % 2 == 1);
        chk("t4_data", (i % 2 == 1) ? core_rdata : aux_rdata,
            (i % 2 == 1) ? 32'hDEADBEEF : 32'h12345678);
      end
      step();
    end
    core_req = 0; aux_req = 0;

    // Reset between a read grant and the next edge
    step();
    core_req = 1; core_addr = 32'h10;
    @(negedge clk);
    chk("t5_gnt", core_gnt, 1);
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_gnt", core_gnt, 0);
    chk("t5_rst_re", mem_ReadEnable, 0);
    chk("t5_rst_rdata", core_rdata, 0);
    step(); core_req = 0;
    step(); reset = 1'b1;
    @(negedge clk);
    chk("t5_no_rvalid", core_rvalid, 0);

    // Out-of-range and misaligned addresses
    step();
    core_req = 1; core_addr = 32'h1000;
    @(negedge clk);
    chk("t6_gnt", core_gnt, 1);
`ifdef DMEM_ARB_ERR_EN
    chk("t6_err", core_err, 1);
    chk("t6_re", mem_ReadEnable, 0);
`else
    chk("t6_err", core_err, 0);
    chk("t6_addr", 32'(mem_address), 0);
`endif
    step(); core_addr = 32'h2;
    @(negedge clk);
`ifdef DMEM_ARB_ERR_EN
    chk("t6_rv0", core_rvalid, 0);
    chk("t6_err2", core_err, 1);
`else
    chk("t6_rdata", core_rdata, 32'hC0DE0000);
`endif
    step(); core_req = 0;
    @(negedge clk);
`ifdef DMEM_ARB_ERR_EN
    chk("t6_rv1", core_rvalid, 0);
`else
    chk("t6_rdata2", core_rdata, 32'hC0DE0000);
`endif

    // Mixed traffic: stores and loads from both ports under contention
    step();
    for (int i = 0; i < 12; i++) begin
      core_req = 1; core_we = (i % 3 == 0); core_addr = 32'(4 * (i % 5));
      core_wdata = 32'hAB00 + 32'(i);
      aux_req = (i % 4 != 3); aux_we = (i % 2 == 0); aux_addr = 32'(4 * (i % 3));
      aux_wdata = 32'hCD00 + 32'(i);
      step();
    end
    core_req = 0; aux_req = 0; core_we = 0; aux_we = 0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
